// File: rtl/membus_arbiter_pkg.sv
// membus_arbiter_pkg
//   Shared definitions for the two-master memory/IO bus arbiter:
//   FSM state encoding, default IO region base, default wait counts and
//   the IO-region address decode helper.
package membus_arbiter_pkg;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   // Default IO window (1 KiB at the top of the address space) and wait counts
   localparam logic [31:0] IO_BASE_DEF  = 32'hFFFFFC00;
   localparam int          IO_WAIT_DEF  = 2;
   localparam int          MEM_WAIT_DEF = 1;

   // An address is in the IO region when its upper 22 bits match the base.
   function automatic logic in_io_region(input logic [31:0] addr,
                                         input logic [31:0] base);
      return (addr[31:10] == base[31:10]);
   endfunction

endpackage

// File: rtl/membus_arbiter_rr_arb2.sv
// rr_arb2
//   Two-input round-robin picker, purely combinational.
//   Ports:
//     req[1:0]    requests from master 0 (bit 0) and master 1 (bit 1)
//     last_grant  index of the master served most recently
//     winner[1:0] one-hot winner, 2'b00 when nobody requests
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] winner
);

   always_comb begin
      winner = 2'b00;
      case (req)
         2'b01:   winner = 2'b01;
         2'b10:   winner = 2'b10;
         // Tie: the master that was not served last goes first.
         2'b11:   winner = last_grant ? 2'b01 : 2'b10;
         default: winner = 2'b00;
      endcase
   end

endmodule

// File: rtl/membus_arbiter.sv
// membus_arbiter
//   Arbitrates two masters onto one shared memory/IO bus. Each transfer runs
//   IDLE -> ACCESS (IO_WAIT or MEM_WAIT cycles) -> DONE. All outputs are
//   registered.
//   Ports:
//     clock, reset (async, active-low)
//     mN_req/we/addr/wdata   request side of master N (N = 0,1)
//     mN_gnt/done/rdata      response side of master N
//     s_addr, s_wdata        shared bus address / write data
//     s_memread/s_memwrite/s_ioread/s_iowrite  shared bus strobes
//     s_mrdata, s_iordata    memory / IO read data
//     busy                   high whenever the FSM is not IDLE
module membus_arbiter
   import membus_arbiter_pkg::*;
#(
   parameter int          IO_WAIT  = IO_WAIT_DEF,
   parameter int          MEM_WAIT = MEM_WAIT_DEF,
   parameter logic [31:0] IO_BASE  = IO_BASE_DEF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_done,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_done,
   output logic [31:0] m1_rdata,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic        s_memread,
   output logic        s_memwrite,
   output logic        s_ioread,
   output logic        s_iowrite,
   input  logic [31:0] s_mrdata,
   input  logic [15:0] s_iordata,
   output logic        busy
);

   // Counter preload: ACCESS lasts (load + 1) cycles.
   localparam logic [3:0] IO_LOAD  = 4'(IO_WAIT - 1);
   localparam logic [3:0] MEM_LOAD = 4'(MEM_WAIT - 1);

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic        last_grant;
   logic        cur;      // master owning the current transfer
   logic        cur_we;
   logic        cur_io;
   logic [1:0]  winner;

   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        sel_io;
   logic [31:0] rd_data;

   rr_arb2 u_rr_arb2 (
      .req        ({m1_req, m0_req}),
      .last_grant (last_grant),
      .winner     (winner)
   );

   assign sel_we    = winner[1] ? m1_we    : m0_we;
   assign sel_addr  = winner[1] ? m1_addr  : m0_addr;
   assign sel_wdata = winner[1] ? m1_wdata : m0_wdata;
   assign sel_io    = in_io_region(sel_addr, IO_BASE);
   assign rd_data   = cur_io ? {16'h0000, s_iordata} : s_mrdata;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         cnt        <= 4'd0;
         last_grant <= 1'b1;
         cur        <= 1'b0;
         cur_we     <= 1'b0;
         cur_io     <= 1'b0;
         m0_gnt     <= 1'b0;
         m1_gnt     <= 1'b0;
         m0_done    <= 1'b0;
         m1_done    <= 1'b0;
         m0_rdata   <= 32'h0;
         m1_rdata   <= 32'h0;
         s_addr     <= 32'h0;
         s_wdata    <= 32'h0;
         s_memread  <= 1'b0;
         s_memwrite <= 1'b0;
         s_ioread   <= 1'b0;
         s_iowrite  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         // gnt and done are single-cycle pulses
         m0_gnt  <= 1'b0;
         m1_gnt  <= 1'b0;
         m0_done <= 1'b0;
         m1_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (winner != 2'b00) begin
                  cur        <= winner[1];
                  cur_we     <= sel_we;
                  cur_io     <= sel_io;
                  s_addr     <= sel_addr;
                  s_wdata    <= sel_we ? sel_wdata : 32'h0;
                  s_memread  <= !sel_io && !sel_we;
                  s_memwrite <= !sel_io &&  sel_we;
                  s_ioread   <=  sel_io && !sel_we;
                  s_iowrite  <=  sel_io &&  sel_we;
                  m0_gnt     <= winner[0];
                  m1_gnt     <= winner[1];
                  cnt        <= sel_io ? IO_LOAD : MEM_LOAD;
                  busy       <= 1'b1;
                  state      <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (cnt == 4'd0) begin
                  s_memread  <= 1'b0;
                  s_memwrite <= 1'b0;
                  s_ioread   <= 1'b0;
                  s_iowrite  <= 1'b0;
                  s_wdata    <= 32'h0;
                  if (!cur_we) begin
                     if (cur) m1_rdata <= rd_data;
                     else     m0_rdata <= rd_data;
                  end
                  m0_done <= !cur;
                  m1_done <=  cur;
                  state   <= ST_DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_DONE: begin
               last_grant <= cur;
               busy       <= 1'b0;
               state      <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_membus_arbiter.sv
// tb_membus_arbiter
//   Directed bench for membus_arbiter: a table of single transfers followed
//   by hand-written sequences for round-robin, reset mid-transfer and a
//   request dropped during ACCESS.
module tb_membus_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_gnt, m0_done, m1_gnt, m1_done;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] s_addr, s_wdata, s_mrdata;
   logic        s_memread, s_memwrite, s_ioread, s_iowrite;
   logic [15:0] s_iordata;
   logic        busy;

   int n_chk  = 0;
   int n_fail = 0;

   membus_arbiter #(.IO_WAIT(2), .MEM_WAIT(1), .IO_BASE(32'hFFFFFC00)) dut (
      .clock(clock), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
      .s_addr(s_addr), .s_wdata(s_wdata),
      .s_memread(s_memread), .s_memwrite(s_memwrite),
      .s_ioread(s_ioread), .s_iowrite(s_iowrite),
      .s_mrdata(s_mrdata), .s_iordata(s_iordata), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] strobes();
      return {s_memread, s_memwrite, s_ioread, s_iowrite};
   endfunction

   // At most one strobe, one gnt and one done in any cycle.
   always @(negedge clock) begin
      if (reset === 1'b1) begin
         chk("one_strobe", 32'($countones(strobes()) <= 1), 32'd1);
         chk("one_gnt",    32'(!(m0_gnt && m1_gnt)),       32'd1);
         chk("one_done",   32'(!(m0_done && m1_done)),     32'd1);
      end
   end

   typedef struct {
      logic        mst;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mrdata;
      logic [15:0] iordata;
      logic [3:0]  strobe;  // {memread, memwrite, ioread, iowrite}
      int          waits;
      logic [31:0] rdata;   // requester's rdata after done
   } vec_t;

   vec_t tbl[8];

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic run_txn(input vec_t v, input string tag);
      int n;
      m0_req = 1'b0; m1_req = 1'b0;
      if (v.mst) begin
         m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
      end else begin
         m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata;
      end
      s_mrdata = v.mrdata; s_iordata = v.iordata;
      step();
      chk({tag, "_gnt"}, {30'h0, m1_gnt, m0_gnt}, v.mst ? 32'd2 : 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      n = 0;
      while (strobes() != 4'b0000 && n < 20) begin
         n++;
         chk({tag, "_strobe"}, 32'(strobes()), 32'(v.strobe));
         chk({tag, "_saddr"}, s_addr, v.addr);
         chk({tag, "_swdata"}, s_wdata, v.we ? v.wdata : 32'h0);
         step();
      end
      chk({tag, "_waits"}, 32'(n), 32'(v.waits));
      chk({tag, "_done"}, {30'h0, m1_done, m0_done}, v.mst ? 32'd2 : 32'd1);
      chk({tag, "_rdata"}, v.mst ? m1_rdata : m0_rdata, v.rdata);
      chk({tag, "_swdata_idle"}, s_wdata, 32'h0);
      m0_req = 1'b0; m1_req = 1'b0;
      step();
      chk({tag, "_idle"}, {30'h0, busy, (m0_done | m1_done)}, 32'd0);
      chk({tag, "_saddr_hold"}, s_addr, v.addr);
   endtask

   initial begin
      int order[4];
      int ng, nd;
      reset = 1'b0;
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
      s_mrdata = 0; s_iordata = 0;

      tbl[0] = '{1'b0, 1'b0, 32'h00000010, 32'h0,        32'h12345678, 16'h0000, 4'b1000, 1, 32'h12345678};
      tbl[1] = '{1'b1, 1'b1, 32'hFFFFFC60, 32'h0000ABCD, 32'hAAAA0000, 16'h5A5A, 4'b0001, 2, 32'h00000000};
      tbl[2] = '{1'b0, 1'b0, 32'hFFFFFC70, 32'h0,        32'hDEADBEEF, 16'hBEEF, 4'b0010, 2, 32'h0000BEEF};
      tbl[3] = '{1'b1, 1'b0, 32'h00001000, 32'h0,        32'hCAFEF00D, 16'h1111, 4'b1000, 1, 32'hCAFEF00D};
      tbl[4] = '{1'b0, 1'b1, 32'h00000020, 32'h5555AAAA, 32'h99999999, 16'h2222, 4'b0100, 1, 32'h0000BEEF};
      tbl[5] = '{1'b1, 1'b1, 32'hFFFFFC00, 32'h13572468, 32'h77777777, 16'h4444, 4'b0001, 2, 32'hCAFEF00D};
      tbl[6] = '{1'b1, 1'b0, 32'hFFFFFBFC, 32'h0,        32'h11112222, 16'h3333, 4'b1000, 1, 32'h11112222};
      tbl[7] = '{1'b0, 1'b0, 32'hFFFFFFFC, 32'h0,        32'h44444444, 16'h1234, 4'b0010, 2, 32'h00001234};

      // Reset state
      #12;
      chk("rst_strobes", 32'(strobes()), 32'd0);
      chk("rst_ctrl", {26'h0, busy, m0_gnt, m1_gnt, m0_done, m1_done, 1'b0}, 32'd0);
      chk("rst_saddr", s_addr, 32'h0);
      chk("rst_swdata", s_wdata, 32'h0);
      chk("rst_m0_rdata", m0_rdata, 32'h0);
      chk("rst_m1_rdata", m1_rdata, 32'h0);
      step();
      reset = 1'b1;

      for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

      // Reset during an IO read
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'hFFFFFC70; s_iordata = 16'hBEEF;
      step();
      chk("rstmid_gnt", 32'(m0_gnt), 32'd1);
      chk("rstmid_ioread", 32'(strobes()), 32'b0010);
      #1 reset = 1'b0;
      #1;
      chk("rstmid_strobes", 32'(strobes()), 32'd0);
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_rdata", m0_rdata, 32'h0);
      m0_req = 1'b0;
      step();
      step();
      reset = 1'b1;
      nd = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (m0_done || m1_done || busy) nd++;
      end
      chk("rstmid_no_done", 32'(nd), 32'd0);

      // Both held high: m0, m1, m0, m1
      m0_we = 1'b0; m0_addr = 32'h00000040;
      m1_we = 1'b0; m1_addr = 32'h00000080;
      s_mrdata = 32'h600DF00D;
      m0_req = 1'b1; m1_req = 1'b1;
      ng = 0;
      for (int i = 0; i < 40 && ng < 4; i++) begin
         step();
         if (m0_gnt) begin order[ng] = 0; ng++; end
         else if (m1_gnt) begin order[ng] = 1; ng++; end
      end
      m0_req = 1'b0; m1_req = 1'b0;
      chk("rr_count", 32'(ng), 32'd4);
      for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 2));
      for (int i = 0; i < 4; i++) step();
      chk("rr_m0_rdata", m0_rdata, 32'h600DF00D);
      chk("rr_m1_rdata", m1_rdata, 32'h600DF00D);
      chk("rr_idle", 32'(busy), 32'd0);

      // m1 drops req during ACCESS
      m1_we = 1'b0; m1_addr = 32'hFFFFFC10; s_iordata = 16'h7777;
      m1_req = 1'b1;
      step();
      chk("drop_gnt", 32'(m1_gnt), 32'd1);
      m1_req = 1'b0;
      nd = 0; ng = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (m1_done) nd++;
         if (m0_gnt || m1_gnt) ng++;
      end
      chk("drop_done_once", 32'(nd), 32'd1);
      chk("drop_no_regrant", 32'(ng), 32'd0);
      chk("drop_rdata", m1_rdata, 32'h00007777);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required end before 200000");
      $fatal(1, "timeout");
   end

endmodule
